// File: rtl/biu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : biu_bridge
// Purpose  : Bus interface unit between one requesting device and one
//            responding slave. Accepts one read/write request at a time,
//            issues it to the slave with a one-cycle strobe, waits for the
//            slave's acknowledge and returns completion to the device.
//            Every output is driven directly from a register.
// Optional : BIU_TIMEOUT_EN - when defined, a WAIT-state counter ends a
//            silent slave access after TIMEOUT_CYCLES cycles. The access then
//            completes with m_error=1, and a read returns all-ones.
//            When undefined, WAIT persists indefinitely and m_error is 0.
// Ports    :
//   clk, rst        - clock (rising edge), synchronous active-high reset
//   m_address       - device request address
//   m_data_out      - device write data
//   m_rnw / m_en    - device read-not-write / request strobe (taken in IDLE)
//   m_data_in       - read data returned to the device (held until next read)
//   m_data_valid    - one-cycle completion pulse
//   m_busy          - transaction in flight
//   m_error         - qualifies m_data_valid; completion was a timeout
//   s_address       - address to slave
//   s_data_out      - write data to slave
//   s_rnw / s_en    - read-not-write / one-cycle request strobe to slave
//   s_data_in       - slave read data
//   s_data_valid    - slave completion acknowledge
// Revision : 1.0 - initial release
// ============================================================================
module biu_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    // device side
    input  logic [ADDR_WIDTH-1:0] m_address,
    input  logic [DATA_WIDTH-1:0] m_data_out,
    input  logic                  m_rnw,
    input  logic                  m_en,
    output logic [DATA_WIDTH-1:0] m_data_in,
    output logic                  m_data_valid,
    output logic                  m_busy,
    output logic                  m_error,
    // slave side
    output logic [ADDR_WIDTH-1:0] s_address,
    output logic [DATA_WIDTH-1:0] s_data_out,
    output logic                  s_rnw,
    output logic                  s_en,
    input  logic [DATA_WIDTH-1:0] s_data_in,
    input  logic                  s_data_valid
);

    // Reject parameter values the timeout counter cannot represent.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("biu_bridge: TIMEOUT_CYCLES must be in 2..65536");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   s_address_q, s_address_d;
    logic [DATA_WIDTH-1:0]   s_data_out_q, s_data_out_d;
    logic                    s_rnw_q, s_rnw_d;
    logic                    s_en_q, s_en_d;
    logic [DATA_WIDTH-1:0]   m_data_in_q, m_data_in_d;
    logic                    m_data_valid_q, m_data_valid_d;
    logic                    m_busy_q, m_busy_d;

`ifdef BIU_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_term = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic                    m_error_q, m_error_d;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Output registers are loaded from
    // the next state so every output lines up with the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        s_address_d  = s_address_q;
        s_data_out_d = s_data_out_q;
        s_rnw_d      = s_rnw_q;
        m_data_in_d  = m_data_in_q;
`ifdef BIU_TIMEOUT_EN
        cnt_d        = cnt_q;
        m_error_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (m_en) begin
                    s_address_d  = m_address;
                    s_data_out_d = m_data_out;
                    s_rnw_d      = m_rnw;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                // Slave cannot acknowledge in the strobe cycle.
                state_d = ST_WAIT;
`ifdef BIU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                // A real acknowledge takes priority over terminal count.
                if (s_data_valid) begin
                    if (s_rnw_q) begin
                        m_data_in_d = s_data_in;
                    end
                    state_d = ST_RESP;
                end
`ifdef BIU_TIMEOUT_EN
                else if (cnt_q == c_cnt_term) begin
                    if (s_rnw_q) begin
                        m_data_in_d = '1;
                    end
                    m_error_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_en_d         = (state_d == ST_REQ);
        m_data_valid_d = (state_d == ST_RESP);
        m_busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            s_address_q    <= '0;
            s_data_out_q   <= '0;
            s_rnw_q        <= 1'b0;
            s_en_q         <= 1'b0;
            m_data_in_q    <= '0;
            m_data_valid_q <= 1'b0;
            m_busy_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_address_q    <= s_address_d;
            s_data_out_q   <= s_data_out_d;
            s_rnw_q        <= s_rnw_d;
            s_en_q         <= s_en_d;
            m_data_in_q    <= m_data_in_d;
            m_data_valid_q <= m_data_valid_d;
            m_busy_q       <= m_busy_d;
        end
    end

`ifdef BIU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            m_error_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            m_error_q <= m_error_d;
        end
    end

    assign m_error = m_error_q;
`else
    assign m_error = 1'b0;
`endif

    assign s_address    = s_address_q;
    assign s_data_out   = s_data_out_q;
    assign s_rnw        = s_rnw_q;
    assign s_en         = s_en_q;
    assign m_data_in    = m_data_in_q;
    assign m_data_valid = m_data_valid_q;
    assign m_busy       = m_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_biu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_biu_bridge
// Purpose  : Self-checking bench for biu_bridge. Table of single transactions
//            plus hand-written back-to-back, reset-in-WAIT and (with
//            BIU_TIMEOUT_EN) timeout sequences. Expected completions are
//            queued when a request is driven and compared when m_data_valid
//            pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biu_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m_address = '0;
    logic [31:0] m_data_out = '0;
    logic        m_rnw = 1'b0;
    logic        m_en = 1'b0;
    logic [31:0] m_data_in;
    logic        m_data_valid;
    logic        m_busy;
    logic        m_error;
    logic [31:0] s_address;
    logic [31:0] s_data_out;
    logic        s_rnw;
    logic        s_en;
    logic [31:0] s_data_in = '0;
    logic        s_data_valid = 1'b0;

    biu_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_address    (m_address),
        .m_data_out   (m_data_out),
        .m_rnw        (m_rnw),
        .m_en         (m_en),
        .m_data_in    (m_data_in),
        .m_data_valid (m_data_valid),
        .m_busy       (m_busy),
        .m_error      (m_error),
        .s_address    (s_address),
        .s_data_out   (s_data_out),
        .s_rnw        (s_rnw),
        .s_en         (s_en),
        .s_data_in    (s_data_in),
        .s_data_valid (s_data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;       // cycles from s_en to s_data_valid (>=1)
        logic [31:0] sdata;
        logic [31:0] exp_data;  // m_data_in expected at completion
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Completion monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (m_data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_data", m_data_in, e.data);
                chk("resp_error", {31'd0, m_error}, {31'd0, e.err});
            end
        end
    end

    // One complete transaction, entered and left at a negedge in IDLE.
    task automatic txn(input vec_t v);
        chk("idle_busy", {31'd0, m_busy}, 32'd0);
        m_en = 1'b1; m_rnw = v.rnw; m_address = v.addr; m_data_out = v.wdata;
        sb.push_back('{v.exp_data, 1'b0});
        @(negedge clk);
        m_en = 1'b0; m_rnw = ~v.rnw; m_address = $urandom; m_data_out = $urandom;
        chk("req_flags", {29'd0, s_en, s_rnw, m_busy}, {29'd0, 1'b1, v.rnw, 1'b1});
        chk("req_addr", s_address, v.addr);
        chk("req_wdata", s_data_out, v.wdata);
        for (int k = 1; k <= v.lat; k++) begin
            @(negedge clk);
            chk("wait_flags", {29'd0, m_data_valid, s_en, m_busy}, 32'd1);
            chk("wait_addr_hold", s_address, v.addr);
        end
        s_data_valid = 1'b1; s_data_in = v.sdata;
        @(negedge clk);
        s_data_valid = 1'b0; s_data_in = $urandom;
        chk("resp_flags", {29'd0, m_data_valid, m_busy, s_en}, 32'b110);
        @(negedge clk);
        chk("done_flags", {30'd0, m_data_valid, m_busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_mdin"}, m_data_in, 32'd0);
        chk({name, "_saddr"}, s_address, 32'd0);
        chk({name, "_sdout"}, s_data_out, 32'd0);
        chk({name, "_flags"}, {27'd0, s_en, s_rnw, m_busy, m_data_valid, m_error}, 32'd0);
    endtask

    vec_t vecs[6];
    vec_t v;
    int   n_sen, n_val;
    logic pend;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0,         2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h1234_5678, 1, 32'hAAAA_5555, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0044, 32'h0,         1, 32'h0000_0001, 32'h0000_0001};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         5, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'h0,         3, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'h0000_0008, 32'h0,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        // Acknowledge while IDLE is ignored
        s_data_valid = 1'b1; s_data_in = 32'h1111_2222;
        @(negedge clk);
        s_data_valid = 1'b0;
        chk("idle_ack_ignored", {30'd0, m_busy, m_data_valid}, 32'd0);
        @(negedge clk);
        chk("idle_ack_ignored2", {30'd0, m_busy, m_data_valid}, 32'd0);

        for (int i = 0; i < 6; i++) txn(vecs[i]);

        // Back-to-back: m_en held, slave acks the cycle after s_en
        m_en = 1'b1; m_rnw = 1'b1; m_address = 32'h300; s_data_in = 32'h0BAD_F00D;
        pend = 1'b0; n_sen = 0; n_val = 0;
        for (int j = 0; j < 4; j++) sb.push_back('{32'h0BAD_F00D, 1'b0});
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (s_en) begin
                n_sen++;
                chk("b2b_s_en_slot", i % 4, 32'd1);
                chk("b2b_s_addr", s_address, 32'h300);
            end
            if (m_data_valid) n_val++;
            chk("b2b_busy", {31'd0, m_busy}, {31'd0, (i % 4) != 0});
            s_data_valid = pend;
            pend = s_en;
        end
        m_en = 1'b0; s_data_valid = 1'b0;
        chk("b2b_s_en_count", n_sen, 32'd4);
        chk("b2b_valid_count", n_val, 32'd4);

        // Reset during WAIT, then a late acknowledge
        m_en = 1'b1; m_rnw = 1'b1; m_address = 32'h500;
        @(negedge clk);
        m_en = 1'b0;
        chk("rw_s_en", {31'd0, s_en}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_in_wait");
        rst = 1'b0; s_data_valid = 1'b1; s_data_in = 32'h0000_0099;
        @(negedge clk);
        s_data_valid = 1'b0;
        chk("late_ack_ignored", {30'd0, m_busy, m_data_valid}, 32'd0);
        @(negedge clk);
        chk("late_ack_ignored2", {30'd0, m_busy, m_data_valid}, 32'd0);
        chk("late_ack_mdin", m_data_in, 32'd0);

        v = '{1'b0, 32'h0000_0204, 32'hCAFE_0001, 2, 32'h7777_7777, 32'h0000_0000};
        txn(v);
        v = '{1'b1, 32'h0000_0200, 32'h0, 1, 32'h1357_9BDF, 32'h1357_9BDF};
        txn(v);

        // Acknowledge arriving on the eighth WAIT cycle
        v = '{1'b1, 32'h0000_0060, 32'h0, 8, 32'h0000_0055, 32'h0000_0055};
        txn(v);

`ifdef BIU_TIMEOUT_EN
        // Silent slave on a read: WAIT cycles 2..9, completion at cycle 10
        m_en = 1'b1; m_rnw = 1'b1; m_address = 32'h40;
        sb.push_back('{32'hFFFF_FFFF, 1'b1});
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            m_en = 1'b0;
            chk("to_wait_valid", {31'd0, m_data_valid}, 32'd0);
        end
        @(negedge clk);
        chk("to_resp", {30'd0, m_data_valid, m_busy}, 32'b11);
        s_data_valid = 1'b1; s_data_in = 32'h0000_ABCD;
        @(negedge clk);
        chk("to_late_ack", {30'd0, m_data_valid, m_busy}, 32'd0);
        @(negedge clk);
        s_data_valid = 1'b0;
        chk("to_late_ack2", {30'd0, m_data_valid, m_busy}, 32'd0);
        chk("to_mdin_kept", m_data_in, 32'hFFFF_FFFF);
`endif

        @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
